// File: rtl/mdio_regs.sv
// mdio_regs: PHY-side clause-22 MDIO frame decoder. Each frame addressed to ADDRESS
// becomes one access on a cyc/stb register bus; read data is returned on mdo.
module mdio_regs #(
  parameter logic [4:0] ADDRESS = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_valid,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [4:0]  addr,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  input  logic        ack,
  input  logic        err
);
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DATA_W = 16;
  localparam logic [CNT_W-1:0] PRE_FULL = 6'd32;

  localparam logic [2:0] S_PRE  = 3'd0;
  localparam logic [2:0] S_ST   = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_PHY  = 3'd3;
  localparam logic [2:0] S_REG  = 3'd4;
  localparam logic [2:0] S_TA   = 3'd5;
  localparam logic [2:0] S_DATA = 3'd6;
  localparam logic [2:0] S_IGN  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] sr_q, sr_d;
  logic              rd_q, rd_d;
  logic [4:0]        phyad_q, phyad_d, regad_q, regad_d;
  logic              cyc_q, cyc_d, we_q, we_d;
  logic [4:0]        addr_q, addr_d;
  logic [DATA_W-1:0] dw_q, dw_d;
  logic              pend_q, pend_d, pend_we_q, pend_we_d;
  logic [4:0]        pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rhave_q, rhave_d;
  logic              mdo_q, mdo_d, mdov_q, mdov_d;

  logic              req, req_we, abort;
  logic [4:0]        req_addr;
  logic [DATA_W-1:0] sr_in;

  assign sr_in = {sr_q, mdi};

  // Frame decode on ce, then bus sequencing (ack, pending issue, new request, abort).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rd_d        = rd_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dw_d        = dw_q;
    pend_d      = pend_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rdat_d      = rdat_q;
    rhave_d     = rhave_q;
    mdo_d       = mdo_q;
    mdov_d      = mdov_q;
    req         = 1'b0;
    req_we      = 1'b0;
    req_addr    = regad_q;
    abort       = 1'b0;

    if (ce) begin
      sr_d = sr_in[DATA_W-2:0];
      case (state_q)
        S_PRE: begin
          if (mdi) begin
            cnt_d = (cnt_q == PRE_FULL) ? PRE_FULL : cnt_q + 6'd1;
          end else begin
            if (cnt_q == PRE_FULL) state_d = S_ST;
            cnt_d = '0;
          end
        end
        S_ST: begin
          cnt_d   = '0;
          state_d = mdi ? S_OP : S_PRE;
        end
        S_OP: begin
          if (cnt_q == '0) begin
            cnt_d = 6'd1;
          end else begin
            cnt_d   = '0;
            rd_d    = sr_q[0];
            state_d = (sr_q[0] ^ mdi) ? S_PHY : S_PRE;
          end
        end
        S_PHY: begin
          if (cnt_q == 6'd4) begin
            phyad_d = sr_in[4:0];
            cnt_d   = '0;
            state_d = S_REG;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_REG: begin
          if (cnt_q == 6'd4) begin
            regad_d = sr_in[4:0];
            cnt_d   = '0;
            if (phyad_q != ADDRESS) begin
              state_d = S_IGN;
              cnt_d   = 6'd18;
            end else begin
              state_d = S_TA;
              if (rd_q) begin
                req      = 1'b1;
                req_addr = sr_in[4:0];
                rhave_d  = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_TA: begin
          if (cnt_q == '0) begin
            cnt_d = 6'd1;
            if (rd_q && rhave_q) begin
              mdo_d  = 1'b0;
              mdov_d = 1'b1;
            end else if (rd_q) begin
              // Read data not ready by turnaround: give up on this frame.
              abort   = 1'b1;
              state_d = S_IGN;
              cnt_d   = 6'd17;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_DATA;
            if (rd_q) begin
              mdo_d  = rdat_q[DATA_W-1];
              rdat_d = {rdat_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (cnt_q == 6'd15) begin
            cnt_d   = '0;
            state_d = S_PRE;
            mdo_d   = 1'b0;
            mdov_d  = 1'b0;
            if (!rd_q) begin
              req    = 1'b1;
              req_we = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
            if (rd_q) begin
              mdo_d  = rdat_q[DATA_W-1];
              rdat_d = {rdat_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        S_IGN: begin
          if (cnt_q == 6'd1) begin
            cnt_d   = '0;
            state_d = S_PRE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_PRE;
        end
      endcase
    end

    if (cyc_q && (ack || err)) begin
      cyc_d = 1'b0;
      if (!we_q && ack) begin
        rdat_d  = data_read;
        rhave_d = 1'b1;
      end
    end
    if (!cyc_q && pend_q) begin
      cyc_d  = 1'b1;
      we_d   = pend_we_q;
      addr_d = pend_addr_q;
      pend_d = 1'b0;
      if (pend_we_q) dw_d = pend_data_q;
    end
    // A request waits behind a bus access still in flight.
    if (req) begin
      if (!cyc_q && !pend_q) begin
        cyc_d  = 1'b1;
        we_d   = req_we;
        addr_d = req_addr;
        if (req_we) dw_d = sr_in;
      end else begin
        pend_d      = 1'b1;
        pend_we_d   = req_we;
        pend_addr_d = req_addr;
        pend_data_d = sr_in;
      end
    end
    if (abort) begin
      if (pend_q && !pend_we_q) pend_d = 1'b0;
      if (cyc_d && !we_d) cyc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PRE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rd_q        <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dw_q        <= '0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rdat_q      <= '0;
      rhave_q     <= 1'b0;
      mdo_q       <= 1'b0;
      mdov_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rd_q        <= rd_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dw_q        <= dw_d;
      pend_q      <= pend_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rdat_q      <= rdat_d;
      rhave_q     <= rhave_d;
      mdo_q       <= mdo_d;
      mdov_q      <= mdov_d;
    end
  end

  assign mdo        = mdo_q;
  assign mdo_valid  = mdov_q;
  assign cyc        = cyc_q;
  assign stb        = cyc_q;
  assign we         = we_q;
  assign addr       = addr_q;
  assign data_write = dw_q;
endmodule

// File: tb/tb_mdio_regs.sv
// tb_mdio_regs: directed MDIO frames with a scoreboard of expected bus accesses
// and expected mdo bits; a small bus responder answers with ack/err/nothing.
module tb_mdio_regs;
  localparam logic [4:0] ADDR = 5'd0;
  localparam int unsigned GAP = 4;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst, ce, mdi, mdo, mdo_valid, cyc, stb, we, ack, err;
  logic [4:0]  addr;
  logic [15:0] data_write, data_read;

  bus_t bus_q[$];
  logic mdo_q[$];
  bus_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   vcnt = 0;
  int   wait_cnt = 0;
  int   ack_dly = 2;
  int   ack_mode = 0;
  logic cyc_prev = 1'b0;
  logic ack_pend = 1'b0;

  always #5 clk = ~clk;

  mdio_regs #(.ADDRESS(ADDR)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mdi(mdi), .mdo(mdo), .mdo_valid(mdo_valid),
    .cyc(cyc), .stb(stb), .we(we), .addr(addr), .data_write(data_write),
    .data_read(data_read), .ack(ack), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled at negedge, bus responder runs here.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    err = 1'b0;
    if (ack_pend) begin
      check("cyc_drop", 32'(cyc), 32'd0);
      ack_pend = 1'b0;
    end
    if (cyc && !cyc_prev) begin
      wait_cnt = ack_dly;
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 32'(cyc), 32'd0);
      end else begin
        cur = bus_q.pop_front();
        check("stb", 32'(stb), 32'd1);
        check("we", 32'(we), 32'(cur.we));
        check("addr", 32'(addr), 32'(cur.addr));
        if (cur.we) check("data_write", 32'(data_write), 32'(cur.data));
      end
    end
    if (cyc && ack_mode != 2) begin
      if (wait_cnt == 0) begin
        check("we_hold", 32'(we), 32'(cur.we));
        check("addr_hold", 32'(addr), 32'(cur.addr));
        if (cur.we) check("data_hold", 32'(data_write), 32'(cur.data));
        if (ack_mode == 1) err = 1'b1;
        else begin
          ack = 1'b1;
          data_read = cur.data;
        end
        ack_pend = 1'b1;
      end else begin
        wait_cnt--;
      end
    end
    cyc_prev = cyc;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ce  = 1'b1;
      mdi = v[i];
      tick();
      if (mdo_valid) begin
        vcnt++;
        if (mdo_q.size() != 0) check("mdo", 32'(mdo), 32'(mdo_q.pop_front()));
        else check("mdo_valid_unexpected", 32'(mdo_valid), 32'd0);
      end
      ce = 1'b0;
      repeat (GAP - 1) tick();
    end
  endtask

  function automatic logic [31:0] body(input logic [1:0] op, input logic [4:0] phy,
                                       input logic [4:0] ra, input logic [15:0] d);
    return {2'b01, op, phy, ra, 2'b10, d};
  endfunction

  task automatic frame(input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] d);
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(body(op, phy, ra, d), 32);
  endtask

  task automatic exp_bus(input logic w, input logic [4:0] a, input logic [15:0] d);
    bus_t e;
    e.we = w;
    e.addr = a;
    e.data = d;
    bus_q.push_back(e);
  endtask

  // Turnaround 0 followed by D15 downward, n samples in total.
  task automatic exp_read(input logic [15:0] d, input int n);
    mdo_q.push_back(1'b0);
    for (int i = 15; i > 16 - n; i--) mdo_q.push_back(d[i]);
  endtask

  task automatic end_check(input string tag, input int exp_v);
    check({tag, "_valid_bits"}, 32'(vcnt), 32'(exp_v));
    check({tag, "_mdo_left"}, 32'(mdo_q.size()), 32'd0);
    check({tag, "_bus_left"}, 32'(bus_q.size()), 32'd0);
    vcnt = 0;
  endtask

  initial begin
    logic [31:0] b;
    rst = 1'b1; ce = 1'b0; mdi = 1'b1; ack = 1'b0; err = 1'b0; data_read = '0;
    repeat (3) tick();
    check("rst_mdo", 32'(mdo), 32'd0);
    check("rst_mdo_valid", 32'(mdo_valid), 32'd0);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data_write", 32'(data_write), 32'd0);
    rst = 1'b0;
    tick();

    // Basic read returning A5C3
    ack_mode = 0; ack_dly = 2;
    exp_bus(1'b0, 5'd2, 16'hA5C3);
    exp_read(16'hA5C3, 17);
    frame(2'b10, ADDR, 5'd2, 16'hFFFF);
    end_check("t1", 17);

    // Write held for several clocks before ack
    ack_dly = 6;
    exp_bus(1'b1, 5'd4, 16'h1234);
    frame(2'b01, ADDR, 5'd4, 16'h1234);
    repeat (12) tick();
    end_check("t2", 0);
    check("t2_cyc_idle", 32'(cyc), 32'd0);

    // 31-one preamble is not enough; then 40 ones (saturating) frame decodes
    ack_dly = 2;
    send_bits(32'h7FFF_FFFF, 31);
    send_bits(body(2'b10, ADDR, 5'd2, 16'hFFFF), 32);
    end_check("t3a", 0);
    exp_bus(1'b0, 5'd7, 16'h0F0F);
    exp_read(16'h0F0F, 17);
    send_bits(32'h0000_00FF, 8);
    frame(2'b10, ADDR, 5'd7, 16'hFFFF);
    end_check("t3b", 17);

    // Other PHY address ignored, following read serviced
    frame(2'b10, ADDR ^ 5'd1, 5'd3, 16'hFFFF);
    end_check("t4a", 0);
    exp_bus(1'b0, 5'd5, 16'h8001);
    exp_read(16'h8001, 17);
    frame(2'b10, ADDR, 5'd5, 16'hFFFF);
    end_check("t4b", 17);

    // Read answered with err, then read never answered
    ack_mode = 1;
    exp_bus(1'b0, 5'd6, 16'h0000);
    frame(2'b10, ADDR, 5'd6, 16'hFFFF);
    end_check("t5a", 0);
    check("t5a_cyc", 32'(cyc), 32'd0);
    ack_mode = 2;
    exp_bus(1'b0, 5'd9, 16'h0000);
    frame(2'b10, ADDR, 5'd9, 16'hFFFF);
    check("t5b_cyc", 32'(cyc), 32'd0);
    end_check("t5b", 0);
    ack_mode = 0; ack_dly = 3;
    exp_bus(1'b1, 5'd3, 16'hBEEF);
    frame(2'b01, ADDR, 5'd3, 16'hBEEF);
    repeat (10) tick();
    end_check("t5c", 0);

    // Reset on DATA bit 8 of a read
    ack_dly = 2;
    exp_bus(1'b0, 5'd1, 16'hC3A5);
    exp_read(16'hC3A5, 9);
    send_bits(32'hFFFF_FFFF, 32);
    b = body(2'b10, ADDR, 5'd1, 16'hFFFF);
    send_bits(b >> 9, 23);
    ce = 1'b1; mdi = 1'b1; rst = 1'b1;
    tick();
    check("t6_mdo_valid", 32'(mdo_valid), 32'd0);
    check("t6_cyc", 32'(cyc), 32'd0);
    rst = 1'b0; ce = 1'b0;
    repeat (3) tick();
    end_check("t6", 9);

    // Recovery after reset
    exp_bus(1'b0, 5'd31, 16'h5AA5);
    exp_read(16'h5AA5, 17);
    frame(2'b10, ADDR, 5'd31, 16'hFFFF);
    end_check("t7", 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
